// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the fetch PC, reads instruction memory
// and hands {inst, pc} to decode over a valid/ready handshake.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  input  logic            rsp_err,
  output logic            valid_next,
  input  logic            ready_next,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic            fetch_fault,
  output logic [31:0]     fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] aligned_pc;

  // fetch_pc keeps redirect low bits; alignment happens on the way out
  assign aligned_pc  = {fetch_pc_q[XLEN-1:2], 2'b00};
  assign req_addr    = aligned_pc;
  assign req_valid   = (state_q == S_REQ) && !rst;
  assign valid_next  = (state_q == S_OUT);
  assign inst        = inst_q;
  assign pc          = pc_q;
  assign fetch_fault = fault_q;
  assign fetch_cnt   = cnt_q;

  // Next-state logic for the request / wait / output sequence
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid)
          fetch_pc_d = redirect_pc;
        if (req_ready) begin
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (redirect_valid)
          fetch_pc_d = redirect_pc;
        if (rsp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = rsp_data;
            pc_d    = aligned_pc;
            fault_d = rsp_err;
            state_d = S_OUT;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          state_d    = S_REQ;
        end else if (ready_next) begin
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          cnt_d      = cnt_q + 32'd1;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC[XLEN-1:0];
      drop_q     <= 1'b0;
      inst_q     <= '0;
      pc_q       <= '0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: fetch sequencing, stalls,
// redirects, faults, PC wrap and reset abandonment.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        valid_next;
  logic        ready_next;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fetch_fault;
  logic [31:0] fetch_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .valid_next     (valid_next),
    .ready_next     (ready_next),
    .inst           (inst),
    .pc             (pc),
    .fetch_fault    (fetch_fault),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one fetch from REQ and land in OUT with a 1-cycle memory
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                       input logic err);
    chk("req_valid", 32'(req_valid), 32'd1);
    chk("req_addr", req_addr, addr);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("wait_vn", 32'(valid_next), 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = data;
    rsp_err   = err;
    tick();
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    chk("out_vn", 32'(valid_next), 32'd1);
    chk("out_inst", inst, data);
    chk("out_pc", pc, addr);
    chk("out_fault", 32'(fetch_fault), 32'(err));
  endtask

  task automatic accept();
    ready_next = 1'b1;
    tick();
    ready_next = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = '0;
    rsp_err = 1'b0;
    ready_next = 1'b0;
    tick();
    tick();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_vn", 32'(valid_next), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_addr", req_addr, 32'h8000_0000);

    // two sequential fetches
    fetch(32'h8000_0000, 32'h0000_0413, 1'b0);
    accept();
    fetch(32'h8000_0004, 32'h0010_0493, 1'b0);
    accept();
    chk("cnt2", fetch_cnt, 32'd2);

    // decode stall for 5 cycles
    fetch(32'h8000_0008, 32'hA5A5_0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_vn", 32'(valid_next), 32'd1);
      chk("stall_inst", inst, 32'hA5A5_0001);
      chk("stall_pc", pc, 32'h8000_0008);
      chk("stall_req", 32'(req_valid), 32'd0);
    end
    chk("stall_cnt", fetch_cnt, 32'd2);
    accept();
    chk("cnt3", fetch_cnt, 32'd3);

    // redirect during WAIT, stale response arrives later
    chk("r3_addr", req_addr, 32'h8000_000C);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    chk("drop_vn0", 32'(valid_next), 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = 32'hDEAD_BEEF;
    tick();
    rsp_valid = 1'b0;
    chk("drop_vn", 32'(valid_next), 32'd0);
    chk("drop_req", 32'(req_valid), 32'd1);
    chk("drop_addr", req_addr, 32'h8000_0100);

    // redirect wins over ready_next in OUT
    fetch(32'h8000_0100, 32'h1111_1111, 1'b0);
    ready_next = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0203;
    tick();
    ready_next = 1'b0;
    redirect_valid = 1'b0;
    chk("kill_vn", 32'(valid_next), 32'd0);
    chk("kill_cnt", fetch_cnt, 32'd3);
    fetch(32'h8000_0200, 32'h2222_2222, 1'b0);
    accept();
    chk("cnt4", fetch_cnt, 32'd4);

    // access fault then clean fetch
    fetch(32'h8000_0204, 32'h0000_0000, 1'b1);
    accept();
    fetch(32'h8000_0208, 32'h3333_3333, 1'b0);
    accept();
    chk("cnt6", fetch_cnt, 32'd6);

    // redirect in REQ without req_ready, then PC wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    fetch(32'hFFFF_FFFC, 32'h4444_4444, 1'b0);
    accept();
    chk("cnt7", fetch_cnt, 32'd7);
    chk("wrap_addr", req_addr, 32'h0000_0000);

    // reset in WAIT, late response ignored
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst2_req", 32'(req_valid), 32'd0);
    rst = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = 32'h5555_5555;
    tick();
    rsp_valid = 1'b0;
    chk("rst2_addr", req_addr, 32'h8000_0000);
    chk("rst2_vn", 32'(valid_next), 32'd0);
    chk("rst2_cnt", fetch_cnt, 32'd0);
    chk("rst2_reqv", 32'(req_valid), 32'd1);
    tick();
    chk("rst2_hold", 32'(valid_next), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
